// File: rtl/ps2_pkg.sv
// Shared constants, FSM state type and event record for the PS/2 scan-code sequencer.
package ps2_pkg;

    // Scan-code prefixes
    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;

    // Controller/keyboard housekeeping bytes that never form part of a key event
    localparam int unsigned PS2_NUM_IGNORED = 8;
    localparam logic [7:0] PS2_IGNORED [PS2_NUM_IGNORED] = '{
        8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF
    };

    // Prefix-tracking states
    typedef enum logic [1:0] {
        StIdle,
        StExt,
        StBrk,
        StExtBrk
    } ps2_state_e;

    // Decoded event, prefixes stripped
    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } ps2_evt_t;

    function automatic logic ps2_is_ignored(input logic [7:0] b);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < int'(PS2_NUM_IGNORED); i++) begin
            if (b == PS2_IGNORED[i]) hit = 1'b1;
        end
        return hit;
    endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// Synchronous event FIFO with level/full/empty and same-cycle push+pop at any level.
module ps2_evt_fifo
    import ps2_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                        i_clk,
    input  logic                        i_clr,
    input  logic                        i_push,
    input  ps2_evt_t                    i_data,
    input  logic                        i_pop,
    output ps2_evt_t                    o_head,
    output logic [$clog2(FIFO_DEPTH):0] o_level,
    output logic                        o_full,
    output logic                        o_empty
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] LEVEL_FULL = (AW + 1)'(FIFO_DEPTH);

    ps2_evt_t    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_level;

    logic w_do_pop;
    logic w_do_push;

    // A full FIFO still accepts a push when the head leaves in the same cycle
    always_comb begin
        o_empty   = (r_level == '0);
        o_full    = (r_level == LEVEL_FULL);
        w_do_pop  = i_pop && !o_empty;
        w_do_push = i_push && (!o_full || w_do_pop);
        o_level   = r_level;
        o_head    = o_empty ? '0 : r_mem[r_rd_ptr];
    end

    // Storage array; contents need no reset since the pointers define validity
    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_data;
    end

    // Pointer and level bookkeeping; pointers wrap naturally at the power-of-2 depth
    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_do_push && !w_do_pop)      r_level <= r_level + 1'b1;
            else if (w_do_pop && !w_do_push) r_level <= r_level - 1'b1;
        end
    end

endmodule

// File: rtl/ps2_scan_ctrl.sv
// PS/2 scan-code sequencer: prefix FSM with timeout, held-key bitmap, event FIFO.
module ps2_scan_ctrl
    import ps2_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned TIMEOUT    = 500000
) (
    input  logic                        i_clk,
    input  logic                        i_clr,
    input  logic [7:0]                  i_byte_data,
    input  logic                        i_byte_valid,
    input  logic                        i_evt_ready,
    output logic                        o_evt_valid,
    output logic [7:0]                  o_evt_code,
    output logic                        o_evt_ext,
    output logic                        o_evt_brk,
    output logic [$clog2(FIFO_DEPTH):0] o_fifo_level,
    output logic [7:0]                  o_held_count,
    output logic                        o_overflow,
    output logic                        o_seq_err
);

    localparam int unsigned TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    ps2_state_e r_state;
    logic [TW-1:0] r_timer;
    logic          r_seq_err;
    logic          r_overflow;
    logic          r_push;
    ps2_evt_t      r_push_evt;
    logic [255:0]  r_held;
    logic [7:0]    r_held_count;

    ps2_state_e w_next_state;
    ps2_evt_t   w_evt;
    logic       w_emit;
    logic       w_err;
    logic       w_ignored;
    logic       w_is_ext;
    logic       w_is_brk;
    logic       w_tracked;
    logic [7:0] w_idx;
    logic       w_held_bit;
    logic       w_repeat;
    logic       w_push;
    ps2_evt_t   w_head;
    logic       w_full;
    logic       w_empty;
    logic       w_pop;

    // Classify the incoming byte and decide the FSM step and any event it produces
    always_comb begin
        w_ignored    = ps2_is_ignored(i_byte_data);
        w_is_ext     = (i_byte_data == PS2_EXT);
        w_is_brk     = (i_byte_data == PS2_BRK);
        w_next_state = r_state;
        w_err        = 1'b0;
        w_emit       = 1'b0;
        w_evt        = '{ext: 1'b0, brk: 1'b0, code: i_byte_data};
        unique case (r_state)
            StIdle: begin
                if (w_is_ext)      w_next_state = StExt;
                else if (w_is_brk) w_next_state = StBrk;
                else if (!w_ignored) w_emit = 1'b1;
            end
            StExt: begin
                if (w_is_brk) begin
                    w_next_state = StExtBrk;
                end else if (w_is_ext) begin
                    w_next_state = StExt;
                    w_err        = 1'b1;
                end else if (w_ignored) begin
                    w_next_state = StIdle;
                    w_err        = 1'b1;
                end else begin
                    w_next_state = StIdle;
                    w_emit       = 1'b1;
                    w_evt.ext    = 1'b1;
                end
            end
            StBrk, StExtBrk: begin
                w_next_state = StIdle;
                if (w_is_ext || w_is_brk || w_ignored) begin
                    w_err = 1'b1;
                end else begin
                    w_emit    = 1'b1;
                    w_evt.brk = 1'b1;
                    w_evt.ext = (r_state == StExtBrk);
                end
            end
            default: w_next_state = StIdle;
        endcase
    end

    // Bitmap lookup; codes with bit 7 set share no slot and are never tracked
    always_comb begin
        w_tracked  = !i_byte_data[7];
        w_idx      = {w_evt.ext, i_byte_data[6:0]};
        w_held_bit = r_held[w_idx];
        w_repeat   = !w_evt.brk && w_tracked && w_held_bit;
        w_push     = i_byte_valid && w_emit && !w_repeat;
    end

    // Prefix FSM, timeout counter, sticky sequence error and the registered push request
    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_state    <= StIdle;
            r_timer    <= '0;
            r_seq_err  <= 1'b0;
            r_push     <= 1'b0;
            r_push_evt <= '0;
        end else begin
            r_push     <= w_push;
            r_push_evt <= w_evt;
            if (i_byte_valid) begin
                r_state <= w_next_state;
                r_timer <= '0;
                if (w_err) r_seq_err <= 1'b1;
            end else if (r_state != StIdle) begin
                if (r_timer == TMO_LAST) begin
                    r_state   <= StIdle;
                    r_timer   <= '0;
                    r_seq_err <= 1'b1;
                end else begin
                    r_timer <= r_timer + 1'b1;
                end
            end else begin
                r_timer <= '0;
            end
        end
    end

    // Held-key bitmap and saturating held-key counter
    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_held       <= '0;
            r_held_count <= '0;
        end else if (i_byte_valid && w_emit && w_tracked) begin
            if (!w_evt.brk && !w_held_bit) begin
                r_held[w_idx] <= 1'b1;
                if (r_held_count != 8'hFF) r_held_count <= r_held_count + 8'd1;
            end else if (w_evt.brk && w_held_bit) begin
                r_held[w_idx] <= 1'b0;
                if (r_held_count != 8'h00) r_held_count <= r_held_count - 8'd1;
            end
        end
    end

    // Sticky overflow: a push lost because the FIFO was full and nothing left
    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_overflow <= 1'b0;
        end else if (r_push && w_full && !w_pop) begin
            r_overflow <= 1'b1;
        end
    end

    assign w_pop = !w_empty && i_evt_ready;

    ps2_evt_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_clr   (i_clr),
        .i_push  (r_push),
        .i_data  (r_push_evt),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_level (o_fifo_level),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Output mapping
    always_comb begin
        o_evt_valid  = !w_empty;
        o_evt_code   = w_head.code;
        o_evt_ext    = w_head.ext;
        o_evt_brk    = w_head.brk;
        o_held_count = r_held_count;
        o_overflow   = r_overflow;
        o_seq_err    = r_seq_err;
    end

endmodule
